// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared state encoding and synchronizer depth for the period meter
package period_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} pm_state_t;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/edge_sync.sv
// edge_sync: two-flop synchronizer followed by a registered one-cycle rising-edge pulse
module edge_sync
  import period_meter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise
);
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic prev_q, prev_d, rise_q, rise_d;
  // shift the raw input through the synchronizer and flag a 0->1 on its output
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], async_in};
    prev_d = sync_q[SYNC_DEPTH-1];
    rise_d = sync_q[SYNC_DEPTH-1] & ~prev_q;
  end
  // synchronizer, history and pulse registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end
  assign rise = rise_q;
endmodule

// File: rtl/period_meter.sv
// period_meter: sums NUM_PERIODS rise-to-rise periods of sig_in in clock cycles; PERIOD_METER_MINMAX_EN adds min/max period outputs
module period_meter
  import period_meter_pkg::*;
#(
  parameter int COUNT_W     = 32,
  parameter int NUM_PERIODS = 16,
  parameter int TIMEOUT_CYC = 50_000_000
)(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               sig_in,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] total_cycles,
  output logic               timeout,
  output logic               overflow
`ifdef PERIOD_METER_MINMAX_EN
  ,
  output logic [COUNT_W-1:0] min_period,
  output logic [COUNT_W-1:0] max_period
`endif
);
  localparam int PW = $clog2(TIMEOUT_CYC + 1);
  localparam int EW = $clog2(NUM_PERIODS + 1);
  pm_state_t state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, total_q, total_d;
  logic [PW-1:0] per_q, per_d;
  logic [EW-1:0] edges_q, edges_d;
  logic timeout_q, timeout_d, overflow_q, overflow_d;
  logic rise, accept, last, expire, tmo, rise_m;
  edge_sync u_sync (.clock(clock), .reset(reset), .async_in(sig_in), .rise(rise));
  // next-state and datapath; per_cnt is the cycles since start or the last rise, so at a rise it equals the period
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    edges_d    = edges_q;
    total_d    = total_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    accept     = state_q == IDLE && start;
    last       = rise && (int'(edges_q) + 1 == NUM_PERIODS);
    expire     = !rise && per_q == PW'(TIMEOUT_CYC);
    tmo        = (state_q == ARM || state_q == MEASURE) && expire;
    rise_m     = state_q == MEASURE && rise;
    case (state_q)
      IDLE: if (start) begin
        state_d    = ARM;
        timeout_d  = 1'b0;
        overflow_d = 1'b0;
        total_d    = '0;
        edges_d    = '0;
        cnt_d      = '0;
        per_d      = PW'(1);
      end
      ARM: begin
        per_d = per_q + 1'b1;
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = COUNT_W'(1);
          per_d   = PW'(1);
          edges_d = '0;
        end
      end
      MEASURE: begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        per_d = per_q + 1'b1;
        if (&cnt_q && !last) overflow_d = 1'b1;
        if (rise) begin
          edges_d = edges_q + 1'b1;
          per_d   = PW'(1);
        end
        if (last) begin
          total_d = cnt_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      timeout_d = 1'b1;
      total_d   = '0;
      state_d   = DONE;
    end
  end
  // state and counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      per_q      <= '0;
      edges_q    <= '0;
      total_q    <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      edges_q    <= edges_d;
      total_q    <= total_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
    end
  end
  assign busy         = state_q == ARM || state_q == MEASURE;
  assign done         = state_q == DONE;
  assign total_cycles = total_q;
  assign timeout      = timeout_q;
  assign overflow     = overflow_q;
`ifdef PERIOD_METER_MINMAX_EN
  logic [COUNT_W-1:0] min_q, min_d, max_q, max_d, period;
  // track extreme single periods at each rise; cleared to 0 when the measurement times out
  always_comb begin
    period = COUNT_W'(per_q);
    min_d  = accept ? '1 : tmo ? '0 : (rise_m && period < min_q) ? period : min_q;
    max_d  = accept ? '0 : tmo ? '0 : (rise_m && period > max_q) ? period : max_q;
  end
  // min/max registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end
  assign min_period = min_q;
  assign max_period = max_q;
`endif
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed and random period measurements against a sum/min/max reference model
module tb_period_meter;
  localparam int W = 32, N = 4, T = 100, WB = 6, NB = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0, start_a = 1'b0, sig_a = 1'b0, start_b = 1'b0, sig_b = 1'b0;
  logic busy_a, done_a, to_a, ov_a, busy_b, done_b, to_b, ov_b;
  logic [W-1:0] tot_a;
  logic [WB-1:0] tot_b;
`ifdef PERIOD_METER_MINMAX_EN
  logic [W-1:0] min_a, max_a;
  logic [WB-1:0] min_b, max_b;
`endif
  period_meter #(.COUNT_W(W), .NUM_PERIODS(N), .TIMEOUT_CYC(T)) u_a (
    .clock(clk), .reset(rst), .start(start_a), .sig_in(sig_a), .busy(busy_a), .done(done_a),
    .total_cycles(tot_a), .timeout(to_a), .overflow(ov_a)
`ifdef PERIOD_METER_MINMAX_EN
    , .min_period(min_a), .max_period(max_a)
`endif
  );
  period_meter #(.COUNT_W(WB), .NUM_PERIODS(NB), .TIMEOUT_CYC(T)) u_b (
    .clock(clk), .reset(rst), .start(start_b), .sig_in(sig_b), .busy(busy_b), .done(done_b),
    .total_cycles(tot_b), .timeout(to_b), .overflow(ov_b)
`ifdef PERIOD_METER_MINMAX_EN
    , .min_period(min_b), .max_period(max_b)
`endif
  );
  int total = 0, bad = 0;
  bit sel_b = 1'b0;
  int per[$];
  logic c_busy, c_done, c_to, c_ov;
  logic [W-1:0] c_tot, c_min, c_max;
  always_comb begin
    c_busy = sel_b ? busy_b : busy_a;
    c_done = sel_b ? done_b : done_a;
    c_to   = sel_b ? to_b : to_a;
    c_ov   = sel_b ? ov_b : ov_a;
    c_tot  = sel_b ? W'(tot_b) : tot_a;
`ifdef PERIOD_METER_MINMAX_EN
    c_min  = sel_b ? W'(min_b) : min_a;
    c_max  = sel_b ? W'(max_b) : max_a;
`else
    c_min  = '0;
    c_max  = '0;
`endif
  end
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic set_sig(bit v);
    if (sel_b) sig_b = v; else sig_a = v;
  endtask
  task automatic set_start(bit v);
    if (sel_b) start_b = v; else start_a = v;
  endtask
  task automatic measure(string tag, int glitch);
    bit wave[$];
    longint sum = 0, lim, mn, mx = 0;
    bit to = 0, seen = 0;
    int nn = sel_b ? NB : N;
    int cyc = 0, bound;
    lim = sel_b ? 64'd63 : 64'hFFFF_FFFF;
    mn = lim;
    wave = {1'b0, 1'b0};
    foreach (per[i]) begin
      repeat (per[i] / 2) wave.push_back(1'b1);
      repeat (per[i] - per[i] / 2) wave.push_back(1'b0);
    end
    repeat (4) wave.push_back(1'b1);
    for (int i = 0; i < nn; i++) begin
      sum += per[i];
      if (per[i] > T) to = 1;
      if (per[i] < mn) mn = per[i];
      if (per[i] > mx) mx = per[i];
    end
    bound = int'(sum) + T + 50;
    @(negedge clk) set_start(1'b1);
    @(negedge clk) set_start(1'b0);
    while (!seen && cyc < bound) begin
      set_sig(cyc < wave.size() ? wave[cyc] : 1'b0);
      set_start(cyc == glitch);
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({tag, " busy_running"}, c_busy, 1);
      if (c_done) seen = 1;
    end
    set_start(1'b0);
    set_sig(1'b0);
    chk({tag, " done_seen"}, seen, 1);
    chk({tag, " busy_at_done"}, c_busy, 0);
    chk({tag, " total"}, c_tot, to ? 0 : (sum > lim ? lim : sum));
    chk({tag, " timeout"}, c_to, to);
    chk({tag, " overflow"}, c_ov, !to && sum > lim);
`ifdef PERIOD_METER_MINMAX_EN
    chk({tag, " min"}, c_min, to ? 0 : mn);
    chk({tag, " max"}, c_max, to ? 0 : mx);
`endif
    @(negedge clk);
    chk({tag, " done_one_cycle"}, c_done, 0);
    repeat (6) @(negedge clk);
  endtask
  initial begin
    int cyc, ndone;
    bit seen;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", busy_a, 0);
    chk("reset done", done_a, 0);
    chk("reset total", tot_a, 0);
    chk("reset flags", {to_a, ov_a}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    per = {10, 10, 10, 10};
    measure("basic", -1);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done_a) seen = 1;
    end
    chk("timeout latency", cyc, 100);
    chk("timeout flag", to_a, 1);
    chk("timeout total", tot_a, 0);
    repeat (4) @(negedge clk);
    per = {10, 10, 10, 10};
    measure("start_ignored", 20);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    for (int i = 0; i < 30; i++) begin
      sig_a = (i % 10) >= 2 && (i % 10) < 7;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("midreset busy", busy_a, 0);
    chk("midreset total", tot_a, 0);
    chk("midreset done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    sig_a = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    chk("midreset no_done", ndone, 0);
    per = {10, 10, 10, 10};
    measure("after_reset", -1);
    per = {100, 100, 100, 100};
    measure("boundary_eq", -1);
    per = {10, 101, 10, 10};
    measure("boundary_over", -1);
    per = {8, 12, 10, 10};
    measure("minmax", -1);
    for (int r = 0; r < 6; r++) begin
      per = {};
      for (int i = 0; i < N; i++) per.push_back(int'($urandom_range(2, 40)));
      if (r == 5) per[$urandom_range(0, N - 1)] = int'($urandom_range(101, 130));
      measure($sformatf("rand%0d", r), -1);
    end
    sel_b = 1'b1;
    per = {50, 50};
    measure("overflow", -1);
    for (int r = 0; r < 3; r++) begin
      per = {int'($urandom_range(2, 25)), int'($urandom_range(2, 25))};
      measure($sformatf("small%0d", r), -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period of a slow, asynchronous square wave in system-clock cycles.
- Typical inputs are a divided clock, an external oscillator or a switch input.
- It is the inverse of the clock divider: the divider derives slow clocks from `clock`; this block recovers a slow clock's period as a cycle count.
- Results feed the HEX display or LED logic for frequency readout and self-check.

Parameters:
- COUNT_W, 32, width of all cycle counters and results.
- NUM_PERIODS, 16, consecutive rising-edge-to-rising-edge periods summed per measurement; must be >= 1.
- TIMEOUT_CYC, 50_000_000, maximum cycles allowed between edges (1 s at 50 MHz); must be >= 2.

Ports:
- clock  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a measurement.
- sig_in  input  1  asynchronous signal being measured.
- busy  output  1  high while a measurement is in progress.
- done  output  1  one-cycle pulse when a result is latched.
- total_cycles  output  COUNT_W  summed cycle count over NUM_PERIODS periods.
- timeout  output  1  result flag: no edge seen within TIMEOUT_CYC.
- overflow  output  1  result flag: the total counter saturated.

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: state IDLE; busy, done, timeout and overflow = 0; total_cycles = 0; all internal counters = 0; synchronizer flops = 0.
- Input conditioning:
  - sig_in passes through a 2-flop synchronizer, then a rising-edge detector.
  - The edge pulse `rise` is high for one cycle, 3 clocks after the sig_in transition.
  - All timing below refers to `rise`.
- State machine:
  - IDLE: busy = 0. On start, go to ARM, clear the timeout and overflow flags, and reset the edge counter and the timeout counter.
  - ARM: busy = 1. Wait for the first `rise`. When it arrives, go to MEASURE: cnt loads 1, per_cnt loads 1, edges loads 0.
  - MEASURE: busy = 1. Each cycle cnt <= cnt + 1, saturating at all-ones; saturation sets overflow (sticky). per_cnt increments every cycle. On `rise`: edges <= edges + 1 and per_cnt <= 1. If edges + 1 == NUM_PERIODS, latch total_cycles <= cnt and go to DONE.
  - DONE: done = 1 for exactly this one cycle, busy = 0, then go to IDLE.
- Counting rule: total_cycles is the exact number of clock cycles between the first and the (NUM_PERIODS+1)th `rise` pulses.
- Timeout:
  - In ARM or MEASURE, when per_cnt reaches TIMEOUT_CYC with no `rise` in that cycle: timeout = 1, total_cycles = 0, go to DONE.
  - per_cnt counts from the start cycle while in ARM.
- Output holding: total_cycles, timeout and overflow hold their values until the next start is accepted.
- Simultaneous events:
  - start while busy or in DONE is ignored.
  - `rise` in the same cycle that per_cnt reaches TIMEOUT_CYC counts as an edge; no timeout is raised.
- Reset mid-measurement: aborts immediately to the reset values; no done pulse.
- Overflow with a valid end: total_cycles = all-ones, overflow = 1, timeout = 0.

Optional Feature:
- Macro: PERIOD_METER_MINMAX_EN.
- When defined, two extra outputs are present:
  - min_period [COUNT_W-1:0], the smallest single period seen in a measurement.
  - max_period [COUNT_W-1:0], the largest single period seen in a measurement.
  - Both are updated from per_cnt at each `rise` in MEASURE.
  - On start accept: min is set to all-ones and max to 0.
  - Both are latched alongside total_cycles.
  - On timeout, both read 0.
- When undefined, these ports and registers do not exist. Core behaviour is identical either way.

Decomposition:
- Package period_meter_pkg contains:
  - typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} pm_state_t;
  - the localparam for the synchronizer depth (2).
- Sub-module edge_sync(clock, reset, async_in, rise): synchronizer plus rising-edge pulse, reusable for buttons and switches.

Test Plan:
- Basic measurement. NUM_PERIODS=4; sig_in toggles every 5 clocks (period 10); pulse start → done after the 5th `rise`, total_cycles = 40, timeout = 0, overflow = 0, busy low in the done cycle.
- Timeout. TIMEOUT_CYC=100; sig_in held 0; pulse start → done exactly 100 cycles after start, timeout = 1, total_cycles = 0.
- Overflow. COUNT_W=6, NUM_PERIODS=2, period 50 → total_cycles = 63, overflow = 1, done asserted.
- Start ignored while busy, then reset. Start again mid-MEASURE → no effect and result still 40. Reset asserted mid-MEASURE → all outputs 0 immediately, no done; a new start then measures correctly.
- Edge at the timeout boundary. TIMEOUT_CYC=10, period exactly 10 → no timeout; total_cycles = 10×NUM_PERIODS.
- With PERIOD_METER_MINMAX_EN. Periods 8, 12, 10, 10 with NUM_PERIODS=4 → min_period = 8, max_period = 12, total_cycles = 40.
